// File: rtl/stream_stim_gen.sv
// stream_stim_gen: deterministic valid/ready stimulus source
//
// Emits `length` beats of a counter, LFSR, walking-rotate or constant
// pattern starting from `seed`. An abort shortens the run: the next
// beat presented after it is marked last.
//
// Parameters: DATA_W (>=2), CNT_W, LFSR_POLY (Galois mask).
// Ports:
//   clk, rst_n               clock, async active-low reset
//   start, abort             run control
//   mode, seed, length       run setup, latched at start
//   busy, done, sent_count   run status
//   m_valid/m_ready/m_data/m_last  output stream
// Optional: `define STREAM_STIM_GEN_GAP_EN adds input gap[7:0], which
// inserts that many idle cycles after every non-final beat.

module stream_stim_gen #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(32'h8020_0003)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [CNT_W-1:0]  length,
`ifdef STREAM_STIM_GEN_GAP_EN
    input  logic [7:0]        gap,
`endif
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sent_count,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  remain_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              abort_q;
    logic              valid_q;
    logic              last_q;
    logic              busy_q;
    logic              done_q;
`ifdef STREAM_STIM_GEN_GAP_EN
    logic [7:0]        gap_q;
    logic [7:0]        gcnt_q;
`endif

    function automatic logic [DATA_W-1:0] advance(
        input logic [1:0]        md,
        input logic [DATA_W-1:0] d
    );
        logic [DATA_W-1:0] r;
        r = d;
        unique case (md)
            2'd0: r = d + DATA_W'(1);
            2'd1: r = (d >> 1) ^ (d[0] ? LFSR_POLY : '0);
            2'd2: r = {d[DATA_W-2:0], d[DATA_W-1]};
            default: r = d;
        endcase
        return r;
    endfunction

    logic              hs;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] seed_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              last_d;

    assign hs     = valid_q & m_ready;
    assign data_d = advance(mode_q, data_q);
    // An all-zero LFSR state would lock up, so seed 0 becomes 1.
    assign seed_d = (mode == 2'd1 && seed == '0) ? DATA_W'(1) : seed;
    assign cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    // Next beat is final if only one remains or an abort is in flight.
    assign last_d = (remain_q == CNT_W'(2)) | abort | abort_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= '0;
            data_q   <= '0;
            remain_q <= '0;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef STREAM_STIM_GEN_GAP_EN
            gap_q    <= '0;
            gcnt_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mode_q   <= mode;
                        data_q   <= seed_d;
                        remain_q <= length;
                        cnt_q    <= '0;
                        abort_q  <= 1'b0;
                        busy_q   <= 1'b1;
`ifdef STREAM_STIM_GEN_GAP_EN
                        gap_q    <= gap;
`endif
                        if (length == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SEND;
                            valid_q <= 1'b1;
                            last_q  <= (length == CNT_W'(1));
                        end
                    end
                end
                S_SEND: begin
                    if (abort) abort_q <= 1'b1;
                    if (hs) begin
                        cnt_q <= cnt_d;
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            data_q   <= data_d;
                            remain_q <= remain_q - CNT_W'(1);
                            last_q   <= last_d;
`ifdef STREAM_STIM_GEN_GAP_EN
                            if (gap_q != 8'd0) begin
                                valid_q <= 1'b0;
                                gcnt_q  <= gap_q;
                                state_q <= S_GAP;
                            end
`endif
                        end
                    end
                end
`ifdef STREAM_STIM_GEN_GAP_EN
                S_GAP: begin
                    // Nothing is presented, so an abort can mark the
                    // upcoming beat last right away.
                    if (abort) begin
                        abort_q <= 1'b1;
                        last_q  <= 1'b1;
                    end
                    if (gcnt_q == 8'd1) begin
                        valid_q <= 1'b1;
                        state_q <= S_SEND;
                    end else begin
                        gcnt_q <= gcnt_q - 8'd1;
                    end
                end
`endif
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign sent_count = cnt_q;
    assign m_valid    = valid_q;
    assign m_data     = data_q;
    assign m_last     = last_q;

endmodule
